// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store from execute, drives the data bus
// with sized, strobed, lane-shifted data, then returns extended load data to writeback.

package common;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

// state | meaning
// IDLE  | ready for a new access from execute
// BUS   | bus request held stable until data_ok
// RESP  | one-cycle completion pulse to writeback
module load_store_unit #(
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [2:0]         req_funct3,
    input  logic [63:0]        req_addr,
    input  logic [63:0]        req_wdata,
    input  logic [4:0]         req_rd,
    output common::dbus_req_t  dreq,
    input  common::dbus_resp_t dresp,
    output logic               resp_valid,
    output logic               resp_wen,
    output logic [4:0]         resp_rd,
    output logic [63:0]        resp_rdata,
    output logic               resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t            state_q, state_d;
    common::dbus_req_t dreq_q, dreq_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              write_q, err_q;
    logic [2:0]        funct3_q, off_q;
    logic [4:0]        rd_q;

    logic              accept;
    logic [1:0]        size_in;
    logic [2:0]        align_mask_in, off_in;
    logic [7:0]        byte_mask_in;
    logic              misalign_in, illegal_in, err_in;
    logic [63:0]       shifted, ext_data;

    // addr_ok is part of the bus protocol but this unit only waits on data_ok
    logic unused_addr_ok;
    assign unused_addr_ok = dresp.addr_ok;

    assign accept = (state_q == S_IDLE) && req_valid;

    // Decode the incoming request: legality, alignment, strobe pattern and lane offset
    always_comb begin
        size_in = req_funct3[1:0];
        case (size_in)
            2'd0:    begin align_mask_in = 3'b000; byte_mask_in = 8'h01; end
            2'd1:    begin align_mask_in = 3'b001; byte_mask_in = 8'h03; end
            2'd2:    begin align_mask_in = 3'b011; byte_mask_in = 8'h0F; end
            default: begin align_mask_in = 3'b111; byte_mask_in = 8'hFF; end
        endcase
        misalign_in = |(req_addr[2:0] & align_mask_in);
        illegal_in  = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
        err_in      = illegal_in || (ERR_ON_MISALIGN && misalign_in);
        // with error reporting off, a misaligned access is forced to its natural boundary
        off_in      = ERR_ON_MISALIGN ? req_addr[2:0] : (req_addr[2:0] & ~align_mask_in);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = err_in ? S_RESP : S_BUS;
            S_BUS:   if (dresp.data_ok) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus request and captured read data: loaded on accept, cleared when the bus completes
    always_comb begin
        dreq_d  = dreq_q;
        rdata_d = rdata_q;
        if (accept && !err_in) begin
            dreq_d.valid  = 1'b1;
            dreq_d.addr   = {req_addr[63:3], off_in};
            dreq_d.size   = {1'b0, size_in};
            dreq_d.strobe = req_write ? (byte_mask_in << off_in) : 8'h00;
            dreq_d.data   = req_wdata << {off_in, 3'b000};
        end else if (state_q == S_BUS && dresp.data_ok) begin
            dreq_d  = '0;
            rdata_d = dresp.data;
        end
    end

    // Datapath registers; request fields are only latched on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dreq_q   <= '0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            rd_q     <= '0;
        end else begin
            dreq_q  <= dreq_d;
            rdata_q <= rdata_d;
            if (accept) begin
                write_q  <= req_write;
                err_q    <= err_in;
                funct3_q <= req_funct3;
                off_q    <= off_in;
                rd_q     <= req_rd;
            end
        end
    end

    // Load extraction: shift the addressed lane down, then sign- or zero-extend
    always_comb begin
        shifted = rdata_q >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'd0:    ext_data = funct3_q[2] ? {56'd0, shifted[7:0]}
                                            : {{56{shifted[7]}}, shifted[7:0]};
            2'd1:    ext_data = funct3_q[2] ? {48'd0, shifted[15:0]}
                                            : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    ext_data = funct3_q[2] ? {32'd0, shifted[31:0]}
                                            : {{32{shifted[31]}}, shifted[31:0]};
            default: ext_data = shifted;
        endcase
    end

    // Outputs, decoded from registered state only
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        dreq       = dreq_q;
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_valid && err_q;
        resp_rd    = resp_valid ? rd_q : 5'd0;
        resp_wen   = resp_valid && !write_q && !err_q && (rd_q != 5'd0);
        resp_rdata = (resp_valid && !write_q && !err_q) ? ext_data : 64'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares whenever resp_valid is seen.
module tb_load_store_unit;
    import common::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        resp_valid, resp_wen, resp_err;
    logic [4:0]  resp_rd;
    logic [63:0] resp_rdata;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .dreq       (dreq),
        .dresp      (dresp),
        .resp_valid (resp_valid),
        .resp_wen   (resp_wen),
        .resp_rd    (resp_rd),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    int compared    = 0;
    int mismatched  = 0;
    int resp_seen   = 0;
    int resp_pushed = 0;

    function automatic exp_t mk(input logic err, input logic wen, input logic [4:0] rd,
                                input logic [63:0] rdata);
        exp_t e;
        e.err = err; e.wen = wen; e.rd = rd; e.rdata = rdata;
        return e;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every cycle with resp_valid consumes exactly one expected response
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            resp_seen++;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_resp: got resp_valid=1 rd=%0d expected no response", resp_rd);
            end else begin
                e = sb.pop_front();
                check64("resp_err",   resp_err,   e.err);
                check64("resp_wen",   resp_wen,   e.wen);
                check64("resp_rd",    resp_rd,    e.rd);
                check64("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    // Issue one access from a negedge in IDLE; returns at the negedge of the next IDLE cycle
    task automatic do_access(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [4:0] rd, input int waits,
                             input logic hold, input logic [63:0] bus_data,
                             input logic [63:0] exp_addr, input logic [2:0] exp_size,
                             input logic [7:0] exp_strobe, input logic [63:0] exp_data,
                             input exp_t exp);
        int guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
            return;
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        sb.push_back(exp);
        resp_pushed++;
        @(negedge clk);
        if (hold) begin
            req_addr  = 64'hDEAD_BEEF_0000_0001;
            req_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
        end else begin
            req_valid = 1'b0;
        end
        if (exp.err) begin
            check64("err_dreq_valid", dreq.valid, 1'b0);
            req_valid = 1'b0;
            @(negedge clk);
            check64("err_ready_back", req_ready, 1'b1);
            return;
        end
        for (int i = 0; i <= waits; i++) begin
            if (i > 0) @(negedge clk);
            check64("dreq_valid",  dreq.valid,  1'b1);
            check64("dreq_addr",   dreq.addr,   exp_addr);
            check64("dreq_size",   dreq.size,   exp_size);
            check64("dreq_strobe", dreq.strobe, exp_strobe);
            check64("dreq_data",   dreq.data,   exp_data);
            check64("bus_ready",   req_ready,   1'b0);
            if (i == waits) begin
                dresp.data_ok = 1'b1;
                dresp.data    = bus_data;
            end
        end
        @(negedge clk);
        dresp.data_ok = 1'b0;
        dresp.data    = 64'd0;
        req_valid     = 1'b0;
        check64("resp_ready_low", req_ready, 1'b0);
        check64("resp_dreq_idle", dreq.valid, 1'b0);
        @(negedge clk);
        check64("ready_back", req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        req_rd     = 5'd0;
        dresp      = '0;
        @(negedge clk);
        @(negedge clk);
        check64("rst_ready",       req_ready,   1'b1);
        check64("rst_dreq_valid",  dreq.valid,  1'b0);
        check64("rst_dreq_addr",   dreq.addr,   64'd0);
        check64("rst_dreq_size",   dreq.size,   3'd0);
        check64("rst_dreq_strobe", dreq.strobe, 8'd0);
        check64("rst_dreq_data",   dreq.data,   64'd0);
        check64("rst_resp_valid",  resp_valid,  1'b0);
        check64("rst_resp_wen",    resp_wen,    1'b0);
        check64("rst_resp_rd",     resp_rd,     5'd0);
        check64("rst_resp_rdata",  resp_rdata,  64'd0);
        check64("rst_resp_err",    resp_err,    1'b0);
        reset = 1'b0;
        @(negedge clk);

        // LD aligned, zero wait states
        do_access(1'b0, 3'b011, 64'h8000_0010, 64'd0, 5'd5, 0, 1'b0, 64'h1122_3344_5566_7788,
                  64'h8000_0010, 3'd3, 8'h00, 64'd0, mk(1'b0, 1'b1, 5'd5, 64'h1122_3344_5566_7788));
        // LB / LBU at offset 3
        do_access(1'b0, 3'b000, 64'h8000_0003, 64'd0, 5'd6, 0, 1'b0, 64'h0000_0000_8000_0000,
                  64'h8000_0003, 3'd0, 8'h00, 64'd0, mk(1'b0, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FF80));
        do_access(1'b0, 3'b100, 64'h8000_0003, 64'd0, 5'd6, 0, 1'b0, 64'h0000_0000_8000_0000,
                  64'h8000_0003, 3'd0, 8'h00, 64'd0, mk(1'b0, 1'b1, 5'd6, 64'h0000_0000_0000_0080));
        // SH lane shift to bytes 6..7
        do_access(1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 5'd7, 0, 1'b0, 64'h5555,
                  64'h8000_0006, 3'd1, 8'hC0, 64'hABCD_0000_0000_0000, mk(1'b0, 1'b0, 5'd7, 64'd0));
        // Misaligned LW reported as error, no bus access
        do_access(1'b0, 3'b010, 64'h8000_0002, 64'd0, 5'd8, 0, 1'b0, 64'd0,
                  64'd0, 3'd0, 8'h00, 64'd0, mk(1'b1, 1'b0, 5'd8, 64'd0));
        // LW with 3 wait states, req_valid held high with changing fields
        do_access(1'b0, 3'b010, 64'h8000_0004, 64'd0, 5'd9, 3, 1'b1, 64'h89AB_CDEF_0000_0000,
                  64'h8000_0004, 3'd2, 8'h00, 64'd0, mk(1'b0, 1'b1, 5'd9, 64'hFFFF_FFFF_89AB_CDEF));
        // Illegal store funct3 and illegal load funct3
        do_access(1'b1, 3'b100, 64'h8000_0000, 64'h1234, 5'd10, 0, 1'b0, 64'd0,
                  64'd0, 3'd0, 8'h00, 64'd0, mk(1'b1, 1'b0, 5'd10, 64'd0));
        do_access(1'b0, 3'b111, 64'h8000_0000, 64'd0, 5'd11, 0, 1'b0, 64'd0,
                  64'd0, 3'd0, 8'h00, 64'd0, mk(1'b1, 1'b0, 5'd11, 64'd0));
        // LH to x0: data extended, no write enable; LHU to x3
        do_access(1'b0, 3'b001, 64'h8000_0002, 64'd0, 5'd0, 0, 1'b0, 64'h0000_0000_8001_0000,
                  64'h8000_0002, 3'd1, 8'h00, 64'd0, mk(1'b0, 1'b0, 5'd0, 64'hFFFF_FFFF_FFFF_8001));
        do_access(1'b0, 3'b101, 64'h8000_0002, 64'd0, 5'd3, 1, 1'b0, 64'h0000_0000_8001_0000,
                  64'h8000_0002, 3'd1, 8'h00, 64'd0, mk(1'b0, 1'b1, 5'd3, 64'h0000_0000_0000_8001));
        // SW upper half with truncation, SB at offset 5, SD full width
        do_access(1'b1, 3'b010, 64'h8000_0004, 64'hFFFF_FFFF_1234_5678, 5'd12, 0, 1'b0, 64'd0,
                  64'h8000_0004, 3'd2, 8'hF0, 64'h1234_5678_0000_0000, mk(1'b0, 1'b0, 5'd12, 64'd0));
        do_access(1'b1, 3'b000, 64'h8000_0005, 64'h0000_0000_0000_AB77, 5'd13, 0, 1'b0, 64'd0,
                  64'h8000_0005, 3'd0, 8'h20, 64'h00AB_7700_0000_0000, mk(1'b0, 1'b0, 5'd13, 64'd0));
        do_access(1'b1, 3'b011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 5'd14, 0, 1'b0, 64'd0,
                  64'h8000_0008, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, mk(1'b0, 1'b0, 5'd14, 64'd0));

        // Reset in the second BUS cycle of an LD
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'h8000_0020;
        req_wdata  = 64'd0;
        req_rd     = 5'd15;
        @(negedge clk);
        req_valid = 1'b0;
        check64("abort_bus_valid", dreq.valid, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check64("abort_dreq_drop", dreq.valid, 1'b0);
        check64("abort_ready",     req_ready,  1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        dresp.data_ok = 1'b0;
        dresp.data    = 64'd0;
        check64("stale_ok_ready", req_ready,  1'b1);
        check64("stale_ok_resp",  resp_valid, 1'b0);
        @(negedge clk);
        do_access(1'b0, 3'b110, 64'h8000_0004, 64'd0, 5'd16, 0, 1'b0, 64'hFFFF_FFFF_0000_0000,
                  64'h8000_0004, 3'd2, 8'h00, 64'd0, mk(1'b0, 1'b1, 5'd16, 64'h0000_0000_FFFF_FFFF));

        repeat (3) @(negedge clk);
        check64("sb_empty",    sb.size(), 64'd0);
        check64("resp_pulses", resp_seen, resp_pushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
